// File: rtl/isa_pkg.sv
// Opcode map, instruction field positions and the decoded-control struct
// shared by the decode/issue stage.
package isa_pkg;

    localparam logic [5:0] OP_AND   = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_ANDI  = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h05;
    localparam logic [5:0] OP_LWPOI = 6'h06;
    localparam logic [5:0] OP_SW    = 6'h07;
    localparam logic [5:0] OP_BEQ   = 6'h08;
    localparam logic [5:0] OP_BLT   = 6'h09;
    localparam logic [5:0] OP_BGE   = 6'h0A;
    localparam logic [5:0] OP_BNE   = 6'h0B;
    localparam logic [5:0] OP_NOP   = 6'h3F;

    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned RS1_LSB = 18;
    localparam int unsigned RS2_LSB = 14;
    localparam int unsigned IMM_LSB = 4;

    typedef struct packed {
        logic reg_write;
        logic post_inc;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic illegal;
        logic uses_rs2;
        logic uses_rd_src;
        logic zext;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opc, input logic [3:0] rd,
                                          input logic [3:0] rs1);
        ctrl_t c;
        c = '0;
        // A post-increment load onto its own base register has no defined result.
        if (opc > OP_BNE || (opc == OP_LWPOI && rd == rs1)) begin
            c.illegal = 1'b1;
        end else if (opc <= OP_SUB) begin
            c.reg_write = 1'b1;
            c.uses_rs2  = 1'b1;
        end else if (opc <= OP_LWPOI) begin
            c.reg_write = 1'b1;
            c.zext      = (opc == OP_ANDI);
            c.mem_read  = (opc >= OP_LW);
            c.post_inc  = (opc == OP_LWPOI);
        end else begin
            c.uses_rd_src = 1'b1;
            c.mem_write   = (opc == OP_SW);
            c.branch      = (opc != OP_SW);
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two write-through read ports, two write ports (port 2 wins
// on a same-address collision), register 0 hardwired to zero.
module regfile #(
    parameter int unsigned NREGS = 16,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic [31:0]   ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [31:0]   rb_data,
    input  logic          w1_en,
    input  logic [AW-1:0] w1_addr,
    input  logic [31:0]   w1_data,
    input  logic          w2_en,
    input  logic [AW-1:0] w2_addr,
    input  logic [31:0]   w2_data
);

    logic [31:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            if (w1_en && w1_addr != '0) mem_q[w1_addr] <= w1_data;
            if (w2_en && w2_addr != '0) mem_q[w2_addr] <= w2_data;
        end
    end

    always_comb begin
        ra_data = mem_q[ra_addr];
        if (w1_en && w1_addr == ra_addr) ra_data = w1_data;
        if (w2_en && w2_addr == ra_addr) ra_data = w2_data;
        if (ra_addr == '0) ra_data = '0;
    end

    always_comb begin
        rb_data = mem_q[rb_addr];
        if (w1_en && w1_addr == rb_addr) rb_data = w1_data;
        if (w2_en && w2_addr == rb_addr) rb_data = w2_data;
        if (rb_addr == '0) rb_data = '0;
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes fetch instructions, reads operands, stalls on
// scoreboard RAW/WAW hazards and registers the ALU request behind valid/ready.
module decode_issue
    import isa_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned IMMW  = 14,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    alu_opcode,
    output logic [31:0]   operand_a,
    output logic [31:0]   operand_b,
    output logic [31:0]   store_data,
    output logic [31:0]   imm_out,
    output logic [31:0]   pc_out,
    output logic [AW-1:0] dest_rd,
    output logic [AW-1:0] dest_rs1,
    output logic          reg_write,
    output logic          post_inc,
    output logic          mem_read,
    output logic          mem_write,
    output logic          branch,
    output logic          illegal,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [31:0]   wb_data,
    input  logic          wb2_en,
    input  logic [AW-1:0] wb2_addr,
    input  logic [31:0]   wb2_data
);

    logic [5:0]      opc;
    logic [AW-1:0]   rd, rs1, rs2, rb_addr;
    logic [IMMW-1:0] imm;
    logic [31:0]     imm_sx, imm_zx, ra_data, rb_data;
    ctrl_t           ctrl;
    logic            unused_lo;

    assign opc       = in_instr[OPC_LSB +: 6];
    assign rd        = in_instr[RD_LSB +: AW];
    assign rs1       = in_instr[RS1_LSB +: AW];
    assign rs2       = in_instr[RS2_LSB +: AW];
    assign imm       = in_instr[IMM_LSB +: IMMW];
    assign imm_sx    = {{(32-IMMW){imm[IMMW-1]}}, imm};
    assign imm_zx    = {{(32-IMMW){1'b0}}, imm};
    assign ctrl      = decode_ctrl(opc, rd, rs1);
    assign rb_addr   = ctrl.uses_rd_src ? rd : rs2;
    assign unused_lo = ^in_instr[IMM_LSB-1:0];

    regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra_addr(rs1),
        .ra_data(ra_data),
        .rb_addr(rb_addr),
        .rb_data(rb_data),
        .w1_en  (wb_en),
        .w1_addr(wb_addr),
        .w1_data(wb_data),
        .w2_en  (wb2_en),
        .w2_addr(wb2_addr),
        .w2_data(wb2_data)
    );

    // Scoreboard and hazard detection
    logic [NREGS-1:0] pending_q, pending_d, wb_clr, pend_wb, src_mask, dst_mask;
    logic             hazard, accept, out_valid_q, out_valid_d;

    always_comb begin
        wb_clr   = '0;
        src_mask = '0;
        dst_mask = '0;
        if (wb_en)  wb_clr[wb_addr]  = 1'b1;
        if (wb2_en) wb_clr[wb2_addr] = 1'b1;
        // Same-cycle writebacks are already visible through the regfile bypass.
        pend_wb = pending_q & ~wb_clr;
        if (!ctrl.illegal) begin
            src_mask[rs1] = 1'b1;
            if (ctrl.uses_rs2)    src_mask[rs2] = 1'b1;
            if (ctrl.uses_rd_src) src_mask[rd]  = 1'b1;
            if (ctrl.reg_write)   dst_mask[rd]  = 1'b1;
            if (ctrl.post_inc)    dst_mask[rs1] = 1'b1;
        end
        src_mask[0] = 1'b0;
        dst_mask[0] = 1'b0;
    end

    assign hazard      = |(pend_wb & (src_mask | dst_mask));
    assign in_ready    = (!out_valid_q || out_ready) && !hazard;
    assign accept      = in_valid && in_ready;
    assign pending_d   = pend_wb | (accept ? dst_mask : '0);
    assign out_valid_d = accept || (out_valid_q && !out_ready);

    // Operand selection
    logic [5:0]    opc_d;
    logic [31:0]   a_d, b_d, st_d, imm_d;
    logic [AW-1:0] drd_d, drs1_d;

    always_comb begin
        opc_d  = OP_NOP;
        a_d    = '0;
        b_d    = '0;
        st_d   = '0;
        imm_d  = '0;
        drd_d  = '0;
        drs1_d = '0;
        if (!ctrl.illegal) begin
            opc_d = opc;
            a_d   = ra_data;
            imm_d = ctrl.zext ? imm_zx : imm_sx;
            b_d   = (ctrl.uses_rs2 || ctrl.branch) ? rb_data : imm_d;
            if (ctrl.mem_write) st_d   = rb_data;
            if (ctrl.reg_write) drd_d  = rd;
            if (ctrl.post_inc)  drs1_d = rs1;
        end
    end

    // Issue register
    logic [5:0]    opc_q;
    logic [31:0]   a_q, b_q, st_q, imm_q, pc_q;
    logic [AW-1:0] drd_q, drs1_q;
    ctrl_t         ctrl_q;
    logic          unused_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pending_q   <= '0;
            opc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            st_q        <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            drd_q       <= '0;
            drs1_q      <= '0;
            ctrl_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pending_q   <= pending_d;
            if (accept) begin
                opc_q  <= opc_d;
                a_q    <= a_d;
                b_q    <= b_d;
                st_q   <= st_d;
                imm_q  <= imm_d;
                pc_q   <= in_pc;
                drd_q  <= drd_d;
                drs1_q <= drs1_d;
                ctrl_q <= ctrl;
            end
        end
    end

    assign unused_ctrl = ^{ctrl_q.uses_rs2, ctrl_q.uses_rd_src, ctrl_q.zext};

    assign out_valid  = out_valid_q;
    assign alu_opcode = opc_q;
    assign operand_a  = a_q;
    assign operand_b  = b_q;
    assign store_data = st_q;
    assign imm_out    = imm_q;
    assign pc_out     = pc_q;
    assign dest_rd    = drd_q;
    assign dest_rs1   = drs1_q;
    assign reg_write  = ctrl_q.reg_write;
    assign post_inc   = ctrl_q.post_inc;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign branch     = ctrl_q.branch;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [5:0]  alu_opcode;
    logic [31:0] operand_a, operand_b, store_data, imm_out, pc_out;
    logic [3:0]  dest_rd, dest_rs1;
    logic        reg_write, post_inc, mem_read, mem_write, branch, illegal;
    logic        wb_en, wb2_en;
    logic [3:0]  wb_addr, wb2_addr;
    logic [31:0] wb_data, wb2_data;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .operand_a(operand_a), .operand_b(operand_b),
        .store_data(store_data), .imm_out(imm_out), .pc_out(pc_out), .dest_rd(dest_rd),
        .dest_rs1(dest_rs1), .reg_write(reg_write), .post_inc(post_inc),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .illegal(illegal),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb2_en(wb2_en), .wb2_addr(wb2_addr), .wb2_data(wb2_data)
    );

    typedef struct packed {
        logic [5:0]  opc;
        logic [31:0] a, b, st, imm, pc;
        logic [3:0]  drd, drs1;
        logic        rw, pi, mr, mw, br, ill;
    } exp_t;

    // Behavioural model state
    logic [31:0] m_reg [16];
    bit          m_pend [16];
    bit          m_ov;
    exp_t        m_out;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 14'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs1, input logic [13:0] imm);
        return {op, rd, rs1, imm, 4'h0};
    endfunction

    function automatic logic [15:0] mpend();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Register value as seen this cycle (writeback bypass, port 2 preferred).
    function automatic logic [31:0] rdv(input logic [3:0] a);
        if (a == 4'd0) return 32'h0;
        if (wb2_en && wb2_addr == a) return wb2_data;
        if (wb_en && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit pend_now(input logic [3:0] a);
        if (a == 4'd0) return 1'b0;
        if ((wb_en && wb_addr == a) || (wb2_en && wb2_addr == a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic bit is_illegal(input logic [31:0] ins);
        return (ins[31:26] > 6'h0B) || (ins[31:26] == 6'h06 && ins[25:22] == ins[21:18]);
    endfunction

    // Every legal class reads or writes rs1 and rd; R-type also reads rs2.
    function automatic bit m_hazard();
        logic [5:0] op = in_instr[31:26];
        if (is_illegal(in_instr)) return 1'b0;
        if (pend_now(in_instr[21:18]) || pend_now(in_instr[25:22])) return 1'b1;
        return (op <= 6'h02) && pend_now(in_instr[17:14]);
    endfunction

    function automatic exp_t m_issue();
        exp_t        e;
        logic [5:0]  op = in_instr[31:26];
        logic [3:0]  rd = in_instr[25:22];
        logic [3:0]  rs1 = in_instr[21:18];
        logic [13:0] im = in_instr[17:4];
        logic [31:0] sx = {{18{im[13]}}, im};
        e = '0;
        e.pc = in_pc;
        if (is_illegal(in_instr)) begin
            e.opc = 6'h3F;
            e.ill = 1'b1;
            return e;
        end
        e.opc = op;
        e.a   = rdv(rs1);
        e.imm = (op == 6'h03) ? {18'h0, im} : sx;
        if (op <= 6'h02) begin
            e.b = rdv(in_instr[17:14]);
            e.rw = 1'b1;
            e.drd = rd;
        end else if (op <= 6'h06) begin
            e.b = e.imm;
            e.rw = 1'b1;
            e.drd = rd;
            e.mr = (op >= 6'h05);
            e.pi = (op == 6'h06);
            e.drs1 = (op == 6'h06) ? rs1 : 4'd0;
        end else if (op == 6'h07) begin
            e.b = sx;
            e.st = rdv(rd);
            e.mw = 1'b1;
        end else begin
            e.b = rdv(rd);
            e.br = 1'b1;
        end
        return e;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_ov = 1'b0;
        m_out = '0;
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("alu_opcode", 32'(alu_opcode), 32'(m_out.opc));
        chk("operand_a", operand_a, m_out.a);
        chk("operand_b", operand_b, m_out.b);
        chk("store_data", store_data, m_out.st);
        chk("imm_out", imm_out, m_out.imm);
        chk("pc_out", pc_out, m_out.pc);
        chk("dest_rd", 32'(dest_rd), 32'(m_out.drd));
        chk("dest_rs1", 32'(dest_rs1), 32'(m_out.drs1));
        chk("flags", 32'({reg_write, post_inc, mem_read, mem_write, branch, illegal}),
            32'({m_out.rw, m_out.pi, m_out.mr, m_out.mw, m_out.br, m_out.ill}));
        chk("pending", 32'(dut.pending_q), 32'(mpend()));
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic step();
        bit          rdy, acc, orr;
        exp_t        e;
        bit          np [16];
        logic [31:0] nr [16];
        #1;
        rdy = !m_hazard() && (!m_ov || out_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        orr = out_ready;
        e = m_issue();
        for (int i = 0; i < 16; i++) begin
            np[i] = pend_now(4'(i));
            nr[i] = m_reg[i];
        end
        if (acc && e.rw && e.drd != 4'd0) np[e.drd] = 1'b1;
        if (acc && e.pi && e.drs1 != 4'd0) np[e.drs1] = 1'b1;
        if (wb_en && wb_addr != 4'd0) nr[wb_addr] = wb_data;
        if (wb2_en && wb2_addr != 4'd0) nr[wb2_addr] = wb2_data;
        @(posedge clk);
        m_pend = np;
        m_reg = nr;
        if (acc) begin
            m_ov = 1'b1;
            m_out = e;
        end else if (orr) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_instr = 32'h0;
        in_pc = 32'h0;
        out_ready = 1'b1;
        wb_en = 1'b0;
        wb_addr = 4'd0;
        wb_data = 32'h0;
        wb2_en = 1'b0;
        wb2_addr = 4'd0;
        wb2_data = 32'h0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc = pc;
    endtask

    function automatic logic [3:0] pick_addr();
        for (int t = 0; t < 4; t++) begin
            logic [3:0] a = 4'($urandom_range(1, 15));
            if (m_pend[a]) return a;
        end
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        idle();
        m_reset();
        repeat (2) @(negedge clk);
        check_out();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // Load R1=5, R2=7, then ADD r3 = r1 + r2
        wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'd5;
        wb2_en = 1'b1; wb2_addr = 4'd2; wb2_data = 32'd7;
        step();
        idle();
        issue(mk_r(6'h01, 4'd3, 4'd1, 4'd2), 32'h100);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_opa", operand_a, 32'd5);
        chk("add_opb", operand_b, 32'd7);
        chk("add_opc", 32'(alu_opcode), 32'h01);
        chk("add_rw", 32'(reg_write), 32'd1);
        chk("add_pend3", 32'(dut.pending_q[3]), 32'd1);

        // SUB reading r3 stalls until its writeback, which is bypassed in
        issue(mk_r(6'h02, 4'd6, 4'd3, 4'd2), 32'h104);
        step();
        step();
        chk("raw_stall", 32'(in_ready), 32'd0);
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'd9;
        step();
        idle();
        chk("raw_opc", 32'(alu_opcode), 32'h02);
        chk("raw_bypass_opa", operand_a, 32'd9);

        // Sign- vs zero-extended immediates
        issue(mk_i(6'h04, 4'd7, 4'd1, 14'h3FFF), 32'h108);
        step();
        chk("addi_opb", operand_b, 32'hFFFF_FFFF);
        issue(mk_i(6'h03, 4'd8, 4'd1, 14'h3FFF), 32'h10C);
        step();
        chk("andi_opb", operand_b, 32'h0000_3FFF);

        // LW.POI sets two pending bits; a later write of r5 is a WAW stall
        issue(mk_i(6'h06, 4'd4, 4'd5, 14'h0010), 32'h110);
        step();
        chk("poi_pi", 32'(post_inc), 32'd1);
        chk("poi_pend45", 32'(dut.pending_q[5:4]), 32'd3);
        issue(mk_i(6'h04, 4'd5, 4'd1, 14'h0001), 32'h114);
        step();
        chk("waw_stall", 32'(in_ready), 32'd0);
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h55;
        step();
        wb_en = 1'b0;

        // Backpressure holds the issued ADDI and blocks the next accept
        out_ready = 1'b0;
        issue(mk_r(6'h01, 4'd9, 4'd1, 4'd2), 32'h118);
        repeat (3) begin
            step();
            chk("bp_hold_opc", 32'(alu_opcode), 32'h04);
            chk("bp_hold_rd", 32'(dest_rd), 32'd5);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_opc", 32'(alu_opcode), 32'h01);
        chk("bp_release_rd", 32'(dest_rd), 32'd9);

        // Illegal opcode issues as a NOP with no scoreboard effect
        issue(mk_r(6'h20, 4'd10, 4'd1, 4'd2), 32'h11C);
        step();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_opc", 32'(alu_opcode), 32'h3F);
        chk("ill_pend10", 32'(dut.pending_q[10]), 32'd0);

        // Reset during a stall
        issue(mk_r(6'h01, 4'd11, 4'd1, 4'd2), 32'h120);
        step();
        out_ready = 1'b0;
        issue(mk_r(6'h02, 4'd12, 4'd11, 4'd2), 32'h124);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_pend", 32'(dut.pending_q), 32'd0);
        @(negedge clk);
        check_out();
        rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(12, 63))
                                              : 6'($urandom_range(0, 11));
            in_valid = ($urandom_range(0, 9) < 7);
            in_instr = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                        4'($urandom_range(0, 7)), 10'($urandom), 4'($urandom)};
            in_pc = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en = ($urandom_range(0, 9) < 4);
            wb_addr = pick_addr();
            wb_data = $urandom;
            wb2_en = ($urandom_range(0, 9) < 3);
            wb2_addr = ($urandom_range(0, 7) == 0) ? wb_addr : pick_addr();
            wb2_data = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
